// File: rtl/lab3_params.sv
// rtl/lab3_params.sv - shared turn-controller state encoding and BCD helper.
package lab3_params;

    typedef enum logic [1:0] {T_IDLE, T_RUN, T_TIMEOUT, T_OVER} turn_state_e;

    // Valid for 0..99; returns {tens, ones}.
    function automatic logic [7:0] bin2bcd99(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

endpackage

// File: rtl/turn_countdown.sv
// rtl/turn_countdown.sv - loadable seconds down-counter, holds at zero, registered zero pulse.
module turn_countdown #(
    parameter int START_SEC = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       en,
    input  logic       tick,
    output logic [6:0] sec,
    output logic       expired_pulse
);

    localparam logic [6:0] START = 7'(START_SEC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec           <= START;
            expired_pulse <= 1'b0;
        end else begin
            expired_pulse <= 1'b0;
            if (load) begin
                sec <= START;
            end else if (en && tick && sec != 7'd0) begin
                sec           <= sec - 7'd1;
                expired_pulse <= (sec == 7'd1);
            end
        end
    end

endmodule

// File: rtl/turn_manager.sv
// rtl/turn_manager.sv - N-player turn controller: countdown, scores, turn LEDs and winner detection.
module turn_manager
    import lab3_params::*;
#(
    parameter int N_PLAYERS  = 2,
    parameter int START_SEC  = 15,
    parameter int WARN_SEC   = 5,
    parameter int SCORE_W    = 4,
    parameter int N_PAIRS    = 8,
    parameter int EXTRA_TURN = 1,
    localparam int PW        = $clog2(N_PLAYERS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         tick_1hz_i,
    input  logic                         game_start_i,
    input  logic                         match_i,
    input  logic                         turn_end_i,
    input  logic                         restart_i,
    input  logic                         pause_i,
    output logic [6:0]                   sec_o,
    output logic [3:0]                   tens_o,
    output logic [3:0]                   ones_o,
    output logic                         time_up_o,
    output logic                         warn_o,
    output logic [PW-1:0]                player_o,
    output logic [N_PLAYERS-1:0]         led_o,
    output logic [N_PLAYERS*SCORE_W-1:0] score_o,
    output logic                         game_over_o,
    output logic [PW-1:0]                winner_o,
    output logic                         tie_o
);

    localparam int TW = SCORE_W + 4;
    localparam logic [SCORE_W-1:0]   SCORE_MAX = '1;
    localparam logic [N_PLAYERS-1:0] ONE_N     = 1;

    turn_state_e        state;
    logic [PW-1:0]      player;
    logic [SCORE_W-1:0] score [N_PLAYERS];

    logic               active, do_match, do_turn, do_restart, load, en, expire_now;
    logic [PW-1:0]      next_player, win;
    logic [SCORE_W-1:0] cur_score, max_score;
    logic [TW-1:0]      total, match_total;
    logic [N_PLAYERS-1:0] top, one_hot;

    // Raw higher-priority pulses mask lower ones even when they are themselves ignored.
    assign active     = (state == T_RUN) || (state == T_TIMEOUT);
    assign do_match   = !game_start_i && active && match_i;
    assign do_turn    = !game_start_i && !match_i && active && turn_end_i;
    assign do_restart = !game_start_i && !match_i && !turn_end_i && active && restart_i;
    assign load       = game_start_i || do_match || do_turn || do_restart;
    assign en         = (state == T_RUN) && !pause_i && !load;
    assign expire_now = en && tick_1hz_i && (sec_o == 7'd1);

    assign next_player = (player == PW'(N_PLAYERS - 1)) ? '0 : player + PW'(1);

    turn_countdown #(.START_SEC(START_SEC)) u_countdown (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (load),
        .en            (en),
        .tick          (tick_1hz_i),
        .sec           (sec_o),
        .expired_pulse (time_up_o)
    );

    always_comb begin
        cur_score = '0;
        total     = '0;
        one_hot   = '0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            total = total + TW'(score[i]);
            if (PW'(i) == player) begin
                cur_score  = score[i];
                one_hot[i] = 1'b1;
            end
        end
        match_total = total + TW'(cur_score != SCORE_MAX);
    end

    // Strict '>' keeps the lowest index among equal maxima.
    always_comb begin
        max_score = '0;
        win       = '0;
        top       = '0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            if (score[i] > max_score) begin
                max_score = score[i];
                win       = PW'(i);
            end
        end
        for (int i = 0; i < N_PLAYERS; i++)
            top[i] = (score[i] == max_score);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= T_IDLE;
            player <= '0;
            for (int i = 0; i < N_PLAYERS; i++) score[i] <= '0;
        end else if (game_start_i) begin
            state  <= T_RUN;
            player <= '0;
            for (int i = 0; i < N_PLAYERS; i++) score[i] <= '0;
        end else if (do_match) begin
            for (int i = 0; i < N_PLAYERS; i++)
                if (PW'(i) == player && cur_score != SCORE_MAX)
                    score[i] <= cur_score + SCORE_W'(1);
            if (EXTRA_TURN == 0) player <= next_player;
            state <= (match_total == TW'(N_PAIRS)) ? T_OVER : T_RUN;
        end else if (do_turn) begin
            player <= next_player;
            state  <= T_RUN;
        end else if (do_restart) begin
            state <= T_RUN;
        end else if (expire_now) begin
            state <= T_TIMEOUT;
        end
    end

    always_comb begin
        for (int i = 0; i < N_PLAYERS; i++) score_o[i*SCORE_W +: SCORE_W] = score[i];
        case (state)
            T_RUN, T_TIMEOUT: led_o = one_hot;
            T_OVER:           led_o = top;
            default:          led_o = '0;
        endcase
    end

    assign {tens_o, ones_o} = bin2bcd99(sec_o);
    assign player_o    = player;
    assign game_over_o = (state == T_OVER);
    assign winner_o    = win;
    assign tie_o       = (state == T_OVER) && ((top & (top - ONE_N)) != '0);
    assign warn_o      = (state == T_RUN) && (sec_o <= 7'(WARN_SEC)) && (sec_o != 7'd0);

endmodule

// File: tb/tb_turn_manager.sv
// tb/tb_turn_manager.sv - directed self-checking bench: 2-player extra-turn DUT and 3-player advancing DUT.
module tb_turn_manager;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick = 1'b0, game_start = 1'b0, match = 1'b0, turn_end = 1'b0, restart = 1'b0, pause = 1'b0;

    logic [6:0] a_sec, b_sec;
    logic [3:0] a_tens, a_ones, b_tens, b_ones;
    logic       a_time_up, a_warn, a_over, a_tie, b_time_up, b_warn, b_over, b_tie;
    logic       a_player, a_winner;
    logic [1:0] b_player, b_winner;
    logic [1:0] a_led;
    logic [2:0] b_led;
    logic [7:0] a_score;
    logic [11:0] b_score;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    turn_manager dut_a (
        .clk(clk), .rst_n(rst_n), .tick_1hz_i(tick), .game_start_i(game_start),
        .match_i(match), .turn_end_i(turn_end), .restart_i(restart), .pause_i(pause),
        .sec_o(a_sec), .tens_o(a_tens), .ones_o(a_ones), .time_up_o(a_time_up),
        .warn_o(a_warn), .player_o(a_player), .led_o(a_led), .score_o(a_score),
        .game_over_o(a_over), .winner_o(a_winner), .tie_o(a_tie)
    );

    turn_manager #(.N_PLAYERS(3), .EXTRA_TURN(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .tick_1hz_i(tick), .game_start_i(game_start),
        .match_i(match), .turn_end_i(turn_end), .restart_i(restart), .pause_i(pause),
        .sec_o(b_sec), .tens_o(b_tens), .ones_o(b_ones), .time_up_o(b_time_up),
        .warn_o(b_warn), .player_o(b_player), .led_o(b_led), .score_o(b_score),
        .game_over_o(b_over), .winner_o(b_winner), .tie_o(b_tie)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Inputs set before the call are sampled on the next edge; outputs read 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
        tick = 0; game_start = 0; match = 0; turn_end = 0; restart = 0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            tick = 1;
            step();
        end
    endtask

    initial begin
        repeat (2) step();
        rst_n = 1'b1;
        check("rst_sec", a_sec, 15);
        check("rst_tens", a_tens, 1);
        check("rst_ones", a_ones, 5);
        check("rst_player", a_player, 0);
        check("rst_led", a_led, 0);
        check("rst_flags", {a_time_up, a_warn, a_over, a_tie}, 0);
        check("rst_winner", a_winner, 0);
        check("rst_score", a_score, 0);
        check("rst_b_led", b_led, 0);

        // Countdown to expiry
        game_start = 1; step();
        check("start_sec", a_sec, 15);
        check("start_led", a_led, 2'b01);
        for (int k = 1; k <= 15; k++) begin
            tick = 1; step();
            if (k == 5)  check("bcd_10", {a_tens, a_ones}, 8'h10);
            if (k == 6)  check("bcd_09", {a_tens, a_ones}, 8'h09);
            if (k == 10) check("warn_at5", a_warn, 1);
            if (k == 14) check("time_up_early", a_time_up, 0);
        end
        check("expire_sec", a_sec, 0);
        check("expire_bcd", {a_tens, a_ones}, 8'h00);
        check("time_up_pulse", a_time_up, 1);
        check("warn_at0", a_warn, 0);
        step();
        check("time_up_one_cycle", a_time_up, 0);
        ticks(1);
        check("timeout_hold", a_sec, 0);
        check("timeout_led", a_led, 2'b01);
        restart = 1; step();
        check("restart_sec", a_sec, 15);
        ticks(1);
        check("restart_runs", a_sec, 14);

        // Three-player turn rotation
        game_start = 1; step();
        check("b_start_led", b_led, 3'b001);
        ticks(2);
        for (int k = 0; k < 3; k++) begin
            turn_end = 1; step();
            check("b_turn_player", b_player, (k + 1) % 3);
            check("b_turn_led", b_led, 3'b001 << ((k + 1) % 3));
            check("b_turn_sec", b_sec, 15);
            ticks(1);
        end

        // Match coincident with a tick
        game_start = 1; step();
        ticks(8);
        check("pre_match_sec", a_sec, 7);
        match = 1; tick = 1; step();
        check("a_match_score", a_score, 8'h01);
        check("a_match_sec", a_sec, 15);
        check("a_match_player", a_player, 0);
        check("b_match_score", b_score[3:0], 1);
        check("b_match_player", b_player, 1);
        check("b_match_led", b_led, 3'b010);
        check("b_match_sec", b_sec, 15);

        // Pause and warning
        ticks(6);
        check("pre_pause", a_sec, 9);
        pause = 1;
        ticks(5);
        check("paused", a_sec, 9);
        pause = 0;
        ticks(1);
        check("resume", a_sec, 8);
        ticks(3);
        check("warn5_sec", a_sec, 5);
        check("warn5", a_warn, 1);
        ticks(4);
        check("warn1", a_warn, 1);
        ticks(1);
        check("warn0", a_warn, 0);
        check("warn0_time_up", a_time_up, 1);

        // Full game ending in a tie
        game_start = 1; step();
        for (int k = 0; k < 4; k++) begin match = 1; step(); end
        turn_end = 1; step();
        for (int k = 0; k < 3; k++) begin match = 1; step(); end
        check("not_over_at7", a_over, 0);
        match = 1; step();
        check("a_over", a_over, 1);
        check("a_tie", a_tie, 1);
        check("a_over_led", a_led, 2'b11);
        check("a_winner", a_winner, 0);
        check("a_final_score", a_score, 8'h44);
        check("b_over", b_over, 1);
        check("b_tie", b_tie, 1);
        check("b_over_led", b_led, 3'b101);
        check("b_final_score", b_score, 12'h323);
        check("b_winner", b_winner, 0);
        match = 1; step();
        check("over_match_ignored", a_score, 8'h44);
        ticks(1);
        check("over_frozen", a_sec, 15);
        game_start = 1; step();
        check("restart_game_score", a_score, 0);
        check("restart_game_over", a_over, 0);
        check("restart_game_led", a_led, 2'b01);
        check("restart_game_tie", a_tie, 0);

        // Asynchronous reset mid-run
        for (int k = 0; k < 3; k++) begin match = 1; step(); end
        turn_end = 1; step();
        for (int k = 0; k < 2; k++) begin match = 1; step(); end
        ticks(2);
        check("pre_rst_score", a_score, 8'h23);
        check("pre_rst_player", a_player, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_sec", a_sec, 15);
        check("async_player", a_player, 0);
        check("async_led", a_led, 0);
        check("async_score", a_score, 0);
        check("async_flags", {a_time_up, a_warn, a_over, a_tie}, 0);
        check("async_winner", a_winner, 0);
        check("async_b_score", b_score, 0);
        step();
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/turn_manager.md
# turn_manager

Parametrised turn controller for the memory game: N players, per-turn countdown, per-player scores and end-of-game detection. It replaces the fixed two-player timer and LED logic that sat beside the game FSM. It sits between the game FSM (match and turn-end events) and the 7-segment and LED outputs. It exposes BCD digits, a one-hot turn LED vector, a warning flag, a timeout pulse and the winner.

## Interface
- N_PLAYERS, 2: number of players (2..8); PW = $clog2(N_PLAYERS).
- START_SEC, 15: countdown reload value (1..99).
- WARN_SEC, 5: warn_o is asserted when sec_o is at or below this value.
- SCORE_W, 4: width of each score counter.
- N_PAIRS, 8: total pairs; the game ends when the sum of scores equals this value.
- EXTRA_TURN, 1: 1 means a match keeps the current player; 0 means a match advances the turn.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- tick_1hz_i  in  1  one-cycle pulse per second.
- game_start_i  in  1  pulse: clear scores and start play with player 0.
- match_i  in  1  pulse: the current player found a pair.
- turn_end_i  in  1  pulse: mismatch, pass the turn.
- restart_i  in  1  pulse: reload the timer without changing player (auto-pick after timeout).
- pause_i  in  1  level: freeze the countdown.
- sec_o  out  7  seconds left, binary.
- tens_o, ones_o  out  4 each  BCD digits of sec_o.
- time_up_o  out  1  one-cycle pulse on expiry.
- warn_o  out  1  low-time flag.
- player_o  out  PW  current player index.
- led_o  out  N_PLAYERS  one-hot turn or winner indicator.
- score_o  out  N_PLAYERS*SCORE_W  packed scores; player i occupies bits [i*SCORE_W +: SCORE_W].
- game_over_o  out  1  level.
- winner_o  out  PW  index of the winning player; valid when game_over_o is 1.
- tie_o  out  1  two or more players share the top score.

## Operation
- States:
  - IDLE (reset).
  - RUN.
  - TIMEOUT.
  - OVER.
- Reset values:
  - State IDLE; sec_o = START_SEC; player_o = 0; all scores 0.
  - led_o = 0; time_up_o, warn_o, game_over_o, tie_o = 0; winner_o = 0.
- Event priority within one cycle, highest first: game_start_i, match_i, turn_end_i, restart_i, tick. A lower-priority event in the same cycle is dropped.
- IDLE/any → game_start_i:
  - Scores cleared, player 0, sec_o = START_SEC.
  - State becomes RUN.
- RUN, tick with !pause_i:
  - sec_o decrements by 1.
  - On the transition 1→0, the state moves to TIMEOUT and time_up_o is high for exactly one cycle.
- RUN/TIMEOUT, match_i:
  - The current player's score is incremented, saturating at 2^SCORE_W−1.
  - sec_o reloads.
  - player_o advances only if EXTRA_TURN = 0.
  - State returns to RUN.
  - If the new score total equals N_PAIRS, the state becomes OVER instead.
- RUN/TIMEOUT, turn_end_i: player_o advances (N_PLAYERS−1 wraps to 0), sec_o reloads, state RUN.
- TIMEOUT, restart_i: sec_o reloads, state RUN, player unchanged. restart_i in RUN also reloads.
- TIMEOUT: sec_o holds at 0 and ticks are ignored.
- OVER:
  - The timer freezes.
  - match_i, turn_end_i and restart_i are ignored.
  - Only game_start_i or reset leaves this state.
- Outputs by state:
  - led_o = one-hot of player_o in RUN/TIMEOUT.
  - In OVER, led_o shows the winner bit, or all top-scoring bits on a tie.
  - In IDLE, led_o = 0.
- winner_o = lowest index with the maximum score; tie_o is asserted if more than one player holds that maximum.
- warn_o = (RUN) && sec_o ≤ WARN_SEC && sec_o ≠ 0.

## Timing
- All state, sec_o, player_o and scores are registered; an event takes effect on the clock edge where it is sampled. Outputs show the new value the following cycle.
- time_up_o is registered and appears in the same cycle that sec_o first reads 0.
- tens_o, ones_o, warn_o, led_o, winner_o and tie_o are combinational from registers, with zero added latency.
- A tick coinciding with a reload is lost, so the reloaded value is START_SEC, not START_SEC−1.
- pause_i high in TIMEOUT or OVER has no effect. Releasing pause resumes on the next tick.
- Asserting reset mid-game forces all reset values immediately, asynchronously.

## Structure
- Add to lab3_params:
  - typedef enum turn_state_e {T_IDLE, T_RUN, T_TIMEOUT, T_OVER}.
  - A function bin2bcd99 for the tens/ones split.
- Sub-module turn_countdown: a loadable down-counter with hold-at-zero and a registered zero pulse. It has inputs load, en and tick, and outputs sec and expired_pulse.
- Score array, priority arbitration and the winner reduction live in turn_manager.

## Test plan
- Reset, then game_start_i, then 15 ticks → sec_o reaches 0 with tens/ones going 1/5 → 0/0. time_up_o is high for 1 cycle, the state is TIMEOUT, and a 16th tick leaves sec_o at 0.
- N_PLAYERS=3, three turn_end_i pulses → player_o goes 1, 2, 0. led_o goes 010, 100, 001, and sec_o = 15 after each pulse.
- match_i coincident with tick at sec_o=7 → score_o[player] +1 and sec_o = 15 (not 14). With EXTRA_TURN=1 the player is unchanged; with EXTRA_TURN=0 the player advances.
- pause_i high for 5 ticks at sec_o=9 → sec_o stays 9. After release, one tick gives 8. warn_o is high at sec_o=5 and low at 0.
- Eight matches split 4/4 between players 0 and 1 → game_over_o=1, tie_o=1, led_o=11, winner_o=0. Later match_i has no effect, and game_start_i clears the scores and sets the state to RUN.
- Assert rst_n low mid-RUN with scores 3/2 → all outputs return to their reset values within the same cycle.
